conv_window_reader: RTL and testbench

- Reads a feature map stored row-major in the single-read-port conv feature RAM (1-cycle registered read latency, 10-bit words, 4096 entries).
- Emits one 3x3 zero-padded window per output pixel as a packed 90-bit word, with a valid/ready handshake.
- Sits between the conv feature RAM read port and the 3x3 MAC array.
- It is the read-side counterpart of the RAM's write path, so a full frame is streamed out as windows for "same" convolution.

---
 rtl/conv_pkg.sv | 41 ++++
 rtl/conv_tap_gen.sv | 43 ++++
 rtl/conv_window_reader.sv | 196 +++++++++++++++++++
 tb/tb_conv_window_reader.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 convolution window reader.
package conv_pkg;

  localparam int DATA_W   = 10;
  localparam int ADDR_W   = 12;
  localparam int NUM_TAPS = 9;
  localparam int TAP_W    = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    DRAIN = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Row offset (0..2, later biased by -1) of tap k = 3*dy + dx.
  function automatic logic [1:0] tap_dy(input logic [TAP_W-1:0] k);
    logic [1:0] dy;
    case (k)
      4'd0, 4'd1, 4'd2: dy = 2'd0;
      4'd3, 4'd4, 4'd5: dy = 2'd1;
      4'd6, 4'd7, 4'd8: dy = 2'd2;
      default:          dy = 2'd0;
    endcase
    return dy;
  endfunction

  // Column offset (0..2, later biased by -1) of tap k = 3*dy + dx.
  function automatic logic [1:0] tap_dx(input logic [TAP_W-1:0] k);
    logic [1:0] dx;
    case (k)
      4'd0, 4'd3, 4'd6: dx = 2'd0;
      4'd1, 4'd4, 4'd7: dx = 2'd1;
      4'd2, 4'd5, 4'd8: dx = 2'd2;
      default:          dx = 2'd0;
    endcase
    return dx;
  endfunction

endpackage

// File: rtl/conv_tap_gen.sv
// Combinational tap address generator: maps (row, col, tap) to a RAM
// address, flagging taps that fall outside the feature map as padding.
module conv_tap_gen #(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int ADDR_W = 12,
  parameter int ROW_W  = 6,
  parameter int COL_W  = 6
) (
  input  logic [ROW_W-1:0]  row,
  input  logic [COL_W-1:0]  col,
  input  logic [3:0]        tap,
  output logic [ADDR_W-1:0] addr,
  output logic              pad
);

  import conv_pkg::*;

  // Two extra bits: one for the sign of row-1 / col-1 and one so that
  // row+1 == IMG_H is representable when IMG_H is a power of two.
  localparam int RW = ROW_W + 2;
  localparam int CW = COL_W + 2;

  logic [RW-1:0] r_s;
  logic [CW-1:0] c_s;
  logic          r_out_s;
  logic          c_out_s;

  // Tap coordinate, bounds check and linear address.
  always_comb begin
    r_s     = RW'(row) + RW'(tap_dy(tap)) - RW'(1'b1);
    c_s     = CW'(col) + CW'(tap_dx(tap)) - CW'(1'b1);
    r_out_s = r_s[RW-1] | (r_s >= RW'(IMG_H));
    c_out_s = c_s[CW-1] | (c_s >= CW'(IMG_W));
    pad     = r_out_s | c_out_s;
    if (pad) begin
      addr = {ADDR_W{1'b0}};
    end else begin
      addr = ADDR_W'(r_s) * ADDR_W'(IMG_W) + ADDR_W'(c_s);
    end
  end

endmodule

// File: rtl/conv_window_reader.sv
// Streams a row-major feature map out of a 1-cycle-latency RAM as
// zero-padded 3x3 windows, one window per output pixel, with valid/ready.
module conv_window_reader #(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int DATA_W = conv_pkg::DATA_W,
  parameter int ADDR_W = conv_pkg::ADDR_W
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  output logic                o_busy,
  output logic [ADDR_W-1:0]   o_addrOut,
  input  logic [DATA_W-1:0]   i_ramData,
  output logic [9*DATA_W-1:0] o_window,
  output logic                o_valid,
  input  logic                i_ready,
  output logic                o_done
);

  import conv_pkg::*;

  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [ROW_W-1:0]   row_r;
  logic [ROW_W-1:0]   row_nxt_s;
  logic [COL_W-1:0]   col_r;
  logic [COL_W-1:0]   col_nxt_s;
  logic [TAP_W-1:0]   tap_r;
  logic [TAP_W-1:0]   tap_nxt_s;
  logic               last_pix_s;

  logic [ADDR_W-1:0]  tap_addr_s;
  logic               tap_pad_s;
  logic [ADDR_W-1:0]  addr_r;
  logic               pad_r;

  logic               cap_vld_r;
  logic [TAP_W-1:0]   cap_tap_r;
  logic               cap_pad_r;
  logic [DATA_W-1:0]  win_r [NUM_TAPS];

  logic               valid_r;
  logic               busy_r;
  logic               done_r;

  // The generator looks at next-cycle counters so the address register
  // presents tap k in the same cycle the FSM sits on tap k.
  conv_tap_gen #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W),
    .ROW_W  (ROW_W),
    .COL_W  (COL_W)
  ) u_tap_gen (
    .row  (row_nxt_s),
    .col  (col_nxt_s),
    .tap  (tap_nxt_s),
    .addr (tap_addr_s),
    .pad  (tap_pad_s)
  );

  // Next-state and counter update logic.
  always_comb begin
    state_nxt_s = state_r;
    row_nxt_s   = row_r;
    col_nxt_s   = col_r;
    tap_nxt_s   = tap_r;
    last_pix_s  = (row_r == ROW_W'(IMG_H - 1)) && (col_r == COL_W'(IMG_W - 1));
    case (state_r)
      IDLE: begin
        if (i_start) begin
          state_nxt_s = FETCH;
          row_nxt_s   = {ROW_W{1'b0}};
          col_nxt_s   = {COL_W{1'b0}};
          tap_nxt_s   = {TAP_W{1'b0}};
        end else begin
          state_nxt_s = IDLE;
        end
      end
      FETCH: begin
        if (tap_r == 4'd8) begin
          state_nxt_s = DRAIN;
        end else begin
          tap_nxt_s = tap_r + 4'd1;
        end
      end
      DRAIN: begin
        state_nxt_s = HOLD;
      end
      HOLD: begin
        if (i_ready) begin
          tap_nxt_s = {TAP_W{1'b0}};
          if (last_pix_s) begin
            state_nxt_s = DONE;
          end else if (col_r == COL_W'(IMG_W - 1)) begin
            state_nxt_s = FETCH;
            col_nxt_s   = {COL_W{1'b0}};
            row_nxt_s   = row_r + ROW_W'(1'b1);
          end else begin
            state_nxt_s = FETCH;
            col_nxt_s   = col_r + COL_W'(1'b1);
          end
        end else begin
          state_nxt_s = HOLD;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, counters and the registered RAM address / pad flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= IDLE;
      row_r   <= {ROW_W{1'b0}};
      col_r   <= {COL_W{1'b0}};
      tap_r   <= {TAP_W{1'b0}};
      addr_r  <= {ADDR_W{1'b0}};
      pad_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      row_r   <= row_nxt_s;
      col_r   <= col_nxt_s;
      tap_r   <= tap_nxt_s;
      if (state_nxt_s == FETCH) begin
        addr_r <= tap_addr_s;
        pad_r  <= tap_pad_s;
      end
    end
  end

  // Delay tap index and pad flag by one cycle to line up with RAM data.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cap_vld_r <= 1'b0;
      cap_tap_r <= {TAP_W{1'b0}};
      cap_pad_r <= 1'b0;
    end else begin
      cap_vld_r <= (state_r == FETCH);
      cap_tap_r <= tap_r;
      cap_pad_r <= pad_r;
    end
  end

  // Capture each returned tap into its window slot, zero for padding.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        win_r[k] <= {DATA_W{1'b0}};
      end
    end else begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        if (cap_vld_r && (cap_tap_r == TAP_W'(k))) begin
          win_r[k] <= cap_pad_r ? {DATA_W{1'b0}} : i_ramData;
        end
      end
    end
  end

  // Registered status flags, decoded from the upcoming state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      valid_r <= (state_nxt_s == HOLD);
      busy_r  <= (state_nxt_s == FETCH) || (state_nxt_s == DRAIN) ||
                 (state_nxt_s == HOLD);
      done_r  <= (state_nxt_s == DONE);
    end
  end

  // Pack the window slots as {w8..w0}.
  always_comb begin
    o_window = {(9*DATA_W){1'b0}};
    for (int k = 0; k < NUM_TAPS; k++) begin
      o_window[k*DATA_W +: DATA_W] = win_r[k];
    end
  end

  assign o_addrOut = addr_r;
  assign o_valid   = valid_r;
  assign o_busy    = busy_r;
  assign o_done    = done_r;

endmodule

// File: tb/tb_conv_window_reader.sv
// Directed bench for conv_window_reader on a 64x64 frame; RAM holds
// mem[a] = a mod 1024 with a 1-cycle registered read.
module tb_conv_window_reader;

  localparam int DW = 10;
  localparam int AW = 12;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_start;
  logic          i_ready;
  logic [AW-1:0] o_addrOut;
  logic [DW-1:0] i_ramData;
  logic [89:0]   o_window;
  logic          o_busy;
  logic          o_valid;
  logic          o_done;

  logic [DW-1:0] mem [4096];

  int vec_cnt  = 0;
  int err_cnt  = 0;
  int win_idx  = -1;
  int done_cnt = 0;

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) i_ramData <= mem[o_addrOut];

  initial begin
    for (int a = 0; a < 4096; a++) mem[a] = 10'(a);
  end

  conv_window_reader #(
    .IMG_W  (64),
    .IMG_H  (64),
    .DATA_W (DW),
    .ADDR_W (AW)
  ) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_start   (i_start),
    .o_busy    (o_busy),
    .o_addrOut (o_addrOut),
    .i_ramData (i_ramData),
    .o_window  (o_window),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_done    (o_done)
  );

  function automatic logic [89:0] pk(input int a0, input int a1, input int a2,
                                     input int a3, input int a4, input int a5,
                                     input int a6, input int a7, input int a8);
    return {10'(a8), 10'(a7), 10'(a6), 10'(a5), 10'(a4),
            10'(a3), 10'(a2), 10'(a1), 10'(a0)};
  endfunction

  task automatic next_window(output bit got);
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge i_clk);
      if (o_done) done_cnt++;
      if (o_valid) got = 1'b1;
    end
    vec_cnt++;
    if (got) begin
      win_idx++;
    end else begin
      err_cnt++;
      $display("FAIL window_timeout: no o_valid after window %0d, required one within 40 cycles", win_idx);
    end
  endtask

  task automatic advance_to(input int idx, output bit ok);
    ok = 1'b1;
    while (ok && win_idx < idx) next_window(ok);
  endtask

  task automatic test_reset();
    i_rst = 1'b0; i_start = 1'b0; i_ready = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b1;
    #1;
    vec_cnt += 5;
    if (o_busy !== 1'b0)     begin err_cnt++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    if (o_valid !== 1'b0)    begin err_cnt++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    if (o_done !== 1'b0)     begin err_cnt++; $display("FAIL reset_done: got %b want 0", o_done); end
    if (o_addrOut !== 12'd0) begin err_cnt++; $display("FAIL reset_addr: got %0d want 0", o_addrOut); end
    if (o_window !== 90'd0)  begin err_cnt++; $display("FAIL reset_window: got %h want 0", o_window); end
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    repeat (3) @(negedge i_clk);
    vec_cnt += 2;
    if (o_busy !== 1'b0)  begin err_cnt++; $display("FAIL idle_busy: got %b want 0", o_busy); end
    if (o_valid !== 1'b0) begin err_cnt++; $display("FAIL idle_valid: got %b want 0", o_valid); end
  endtask

  // Start a frame and check latency and window (0,0).
  task automatic test_first_window(input string tag);
    int cyc;
    i_ready = 1'b1;
    @(negedge i_clk);
    i_start = 1'b1; done_cnt = 0; win_idx = -1;
    @(negedge i_clk);
    i_start = 1'b0; cyc = 1;
    vec_cnt += 2;
    if (o_busy !== 1'b1)     begin err_cnt++; $display("FAIL %s_busy_c1: got %b want 1", tag, o_busy); end
    if (o_addrOut !== 12'd0) begin err_cnt++; $display("FAIL %s_addr_tap0: got %0d want 0", tag, o_addrOut); end
    while (!o_valid && cyc < 40) begin
      @(negedge i_clk);
      cyc++;
      if (cyc == 6) begin
        vec_cnt++;
        if (o_addrOut !== 12'd1) begin err_cnt++; $display("FAIL %s_addr_tap5: got %0d want 1", tag, o_addrOut); end
      end
    end
    win_idx = 0;
    vec_cnt += 2;
    if (cyc != 11) begin err_cnt++; $display("FAIL %s_latency: o_valid in cycle %0d want 11", tag, cyc); end
    if (o_window !== pk(0, 0, 0, 0, 0, 1, 0, 64, 65)) begin
      err_cnt++; $display("FAIL %s_win_0_0: got %h want %h", tag, o_window, pk(0, 0, 0, 0, 0, 1, 0, 64, 65));
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit ok;
    cyc = 0;
    @(negedge i_clk);
    cyc = 1;
    vec_cnt++;
    if (o_valid !== 1'b0) begin err_cnt++; $display("FAIL valid_drop: got %b want 0", o_valid); end
    while (!o_valid && cyc < 40) begin
      @(negedge i_clk);
      cyc++;
    end
    win_idx = 1;
    vec_cnt += 2;
    if (cyc != 11) begin err_cnt++; $display("FAIL throughput: next window after %0d cycles want 11", cyc); end
    if (o_window !== pk(0, 0, 0, 0, 1, 2, 64, 65, 66)) begin
      err_cnt++; $display("FAIL win_0_1: got %h want %h", o_window, pk(0, 0, 0, 0, 1, 2, 64, 65, 66));
    end
    advance_to(63, ok);
    if (!ok) return;
    vec_cnt++;
    if (o_window !== pk(0, 0, 0, 62, 63, 0, 126, 127, 0)) begin
      err_cnt++; $display("FAIL win_0_63: got %h want %h", o_window, pk(0, 0, 0, 62, 63, 0, 126, 127, 0));
    end
    advance_to(65, ok);
    if (!ok) return;
    vec_cnt++;
    if (o_window !== pk(0, 1, 2, 64, 65, 66, 128, 129, 130)) begin
      err_cnt++; $display("FAIL win_1_1: got %h want %h", o_window, pk(0, 1, 2, 64, 65, 66, 128, 129, 130));
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int start_idx;
    advance_to(327, ok);
    if (!ok) return;
    i_ready = 1'b0;
    start_idx = win_idx;
    for (int c = 0; c < 20; c++) begin
      @(negedge i_clk);
      vec_cnt += 3;
      if (o_valid !== 1'b1) begin err_cnt++; $display("FAIL bp_valid c%0d: got %b want 1", c, o_valid); end
      if (o_window !== pk(262, 263, 264, 326, 327, 328, 390, 391, 392)) begin
        err_cnt++; $display("FAIL bp_window c%0d: got %h want centre 327", c, o_window);
      end
      if (o_addrOut !== 12'd392) begin err_cnt++; $display("FAIL bp_addr c%0d: got %0d want 392", c, o_addrOut); end
    end
    i_ready = 1'b1;
    next_window(ok);
    if (!ok) return;
    vec_cnt += 2;
    if (win_idx != start_idx + 1) begin err_cnt++; $display("FAIL bp_count: index %0d want %0d", win_idx, start_idx + 1); end
    if (o_window !== pk(263, 264, 265, 327, 328, 329, 391, 392, 393)) begin
      err_cnt++; $display("FAIL win_5_8: got %h want centre 328", o_window);
    end
  endtask

  task automatic test_start_ignored();
    bit ok;
    advance_to(1000, ok);
    if (!ok) return;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    advance_to(2000, ok);
    if (!ok) return;
    @(negedge i_clk);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    vec_cnt++;
    if (o_busy !== 1'b1) begin err_cnt++; $display("FAIL start_busy: got %b want 1", o_busy); end
  endtask

  task automatic test_last_window();
    bit ok;
    int extra;
    advance_to(4032, ok);
    if (!ok) return;
    vec_cnt++;
    if (o_window !== pk(0, 896, 897, 0, 960, 961, 0, 0, 0)) begin
      err_cnt++; $display("FAIL win_63_0: got %h want %h", o_window, pk(0, 896, 897, 0, 960, 961, 0, 0, 0));
    end
    advance_to(4095, ok);
    if (!ok) return;
    vec_cnt++;
    if (o_window !== pk(958, 959, 0, 1022, 1023, 0, 0, 0, 0)) begin
      err_cnt++; $display("FAIL win_63_63: got %h want %h", o_window, pk(958, 959, 0, 1022, 1023, 0, 0, 0, 0));
    end
    @(negedge i_clk);
    if (o_done) done_cnt++;
    vec_cnt += 3;
    if (o_done !== 1'b1)  begin err_cnt++; $display("FAIL done_pulse: got %b want 1", o_done); end
    if (o_busy !== 1'b0)  begin err_cnt++; $display("FAIL done_busy: got %b want 0", o_busy); end
    if (o_valid !== 1'b0) begin err_cnt++; $display("FAIL done_valid: got %b want 0", o_valid); end
    extra = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge i_clk);
      if (o_done) done_cnt++;
      if (o_valid) extra++;
    end
    vec_cnt += 3;
    if (win_idx + 1 != 4096) begin err_cnt++; $display("FAIL frame_windows: got %0d want 4096", win_idx + 1); end
    if (done_cnt != 1)       begin err_cnt++; $display("FAIL frame_done_count: got %0d want 1", done_cnt); end
    if (extra != 0)          begin err_cnt++; $display("FAIL frame_extra_valid: got %0d want 0", extra); end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    int seen;
    test_first_window("f2");
    advance_to(100, ok);
    if (!ok) return;
    i_rst = 1'b1;
    #1;
    vec_cnt += 5;
    if (o_busy !== 1'b0)     begin err_cnt++; $display("FAIL abort_busy: got %b want 0", o_busy); end
    if (o_valid !== 1'b0)    begin err_cnt++; $display("FAIL abort_valid: got %b want 0", o_valid); end
    if (o_done !== 1'b0)     begin err_cnt++; $display("FAIL abort_done: got %b want 0", o_done); end
    if (o_addrOut !== 12'd0) begin err_cnt++; $display("FAIL abort_addr: got %0d want 0", o_addrOut); end
    if (o_window !== 90'd0)  begin err_cnt++; $display("FAIL abort_window: got %h want 0", o_window); end
    @(negedge i_clk);
    i_rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge i_clk);
      if (o_done || o_valid || o_busy) seen++;
    end
    vec_cnt++;
    if (seen != 0) begin err_cnt++; $display("FAIL abort_quiet: %0d active cycles want 0", seen); end
    test_first_window("f3");
  endtask

  initial begin
    test_reset();
    test_first_window("f1");
    test_back_to_back();
    test_backpressure();
    test_start_ignored();
    test_last_window();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
